// File: rtl/fp_round_pack.sv
// Rounding and packing stage of the binary32 add/sub datapath: applies the RISC-V rounding
// mode to a normalized significand and emits the packed result plus fflags through two stages.
module fp_round_pack #(
    parameter int unsigned EXP_W = 10,
    parameter int unsigned SIG_W = 27
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic signed [EXP_W-1:0] in_exp,
    input  logic        [SIG_W-1:0] in_sig,
    input  logic        [2:0]       in_rm,
    input  logic                    in_is_nan,
    input  logic                    in_is_inf,
    input  logic        [4:0]       in_flags,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic        [31:0]      out_result,
    output logic        [4:0]       out_flags
);

    localparam int unsigned SumW = SIG_W - 2;

    localparam logic [2:0] RmRne = 3'b000;
    localparam logic [2:0] RmRtz = 3'b001;
    localparam logic [2:0] RmRdn = 3'b010;
    localparam logic [2:0] RmRup = 3'b011;
    localparam logic [2:0] RmRmm = 3'b100;

    localparam logic [30:0] MagInf  = 31'h7F80_0000;
    localparam logic [30:0] MagMax  = 31'h7F7F_FFFF;
    localparam logic [31:0] QNan    = 32'h7FC0_0000;
    localparam logic [4:0]  FlagsOf = 5'b00101;
    localparam logic [4:0]  FlagsUf = 5'b00011;

    // Handshake
    logic s1_valid;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // Stage 1: rounding increment
    logic            lsb, g, r, s, inexact, inc;
    logic [2:0]      rm_n;
    logic [SumW-1:0] sum;

    always_comb begin
        lsb     = in_sig[3];
        g       = in_sig[2];
        r       = in_sig[1];
        s       = in_sig[0];
        inexact = g | r | s;
        // Reserved encodings fall back to round-to-nearest-even.
        rm_n    = (in_rm > RmRmm) ? RmRne : in_rm;
        inc     = 1'b0;
        unique case (rm_n)
            RmRne:   inc = g & (r | s | lsb);
            RmRtz:   inc = 1'b0;
            RmRdn:   inc = inexact & in_sign;
            RmRup:   inc = inexact & ~in_sign;
            RmRmm:   inc = g;
            default: inc = 1'b0;
        endcase
        sum = {1'b0, in_sig[SIG_W-1:3]} + {{(SumW-1){1'b0}}, inc};
    end

    logic                    s1_sign;
    logic signed [EXP_W-1:0] s1_exp;
    logic        [SumW-1:0]  s1_sum;
    logic        [2:0]       s1_rm;
    logic                    s1_inexact;
    logic                    s1_nan;
    logic                    s1_inf;
    logic        [4:0]       s1_flags;

    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            s1_sign    <= in_sign;
            s1_exp     <= in_exp;
            s1_sum     <= sum;
            s1_rm      <= rm_n;
            s1_inexact <= inexact;
            s1_nan     <= in_is_nan;
            s1_inf     <= in_is_inf;
            s1_flags   <= in_flags;
        end
    end

    // Stage 2: carry-out, overflow/underflow and packing
    logic signed [EXP_W:0] exp_f;
    logic        [22:0]    mant;
    logic        [30:0]    ovf_mag;
    logic                  uf;
    logic        [31:0]    res_d;
    logic        [4:0]     flg_d;

    always_comb begin
        exp_f = {s1_exp[EXP_W-1], s1_exp} + {{EXP_W{1'b0}}, s1_sum[SumW-1]};
        mant  = s1_sum[SumW-1] ? s1_sum[SumW-2:1] : s1_sum[SumW-3:0];
        // A subnormal that rounds up into the hidden bit becomes the smallest normal.
        if (!s1_sum[SumW-1] && (s1_exp == '0) && s1_sum[SumW-2]) begin
            exp_f = (EXP_W+1)'(1);
        end

        ovf_mag = MagInf;
        unique case (s1_rm)
            RmRtz:   ovf_mag = MagMax;
            RmRdn:   ovf_mag = s1_sign ? MagInf : MagMax;
            RmRup:   ovf_mag = s1_sign ? MagMax : MagInf;
            default: ovf_mag = MagInf;
        endcase

        uf    = s1_inexact && (exp_f[7:0] == 8'h00);
        res_d = {s1_sign, exp_f[7:0], mant};
        flg_d = {3'b000, uf, s1_inexact};

        if (s1_nan) begin
            res_d = QNan;
            flg_d = '0;
        end else if (s1_inf) begin
            res_d = {s1_sign, MagInf};
            flg_d = '0;
        end else if (s1_exp[EXP_W-1]) begin
            res_d = {s1_sign, 31'h0};
            flg_d = FlagsUf;
        end else if (exp_f >= (EXP_W+1)'(255)) begin
            res_d = {s1_sign, ovf_mag};
            flg_d = FlagsOf;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_result <= res_d;
                    out_flags  <= s1_flags | flg_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_round_pack.sv
// Vector table plus scoreboard bench for fp_round_pack: expected results are queued at
// accept time and compared as the DUT hands them off, plus backpressure and reset sequences.
module tb_fp_round_pack;

    typedef struct packed {
        logic        sign;
        logic [9:0]  exp;
        logic [26:0] sig;
        logic [2:0]  rm;
        logic        nan;
        logic        inf;
        logic [4:0]  flags;
        logic [31:0] res;
        logic [4:0]  eflags;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [9:0]  in_exp = '0;
    logic [26:0] in_sig = '0;
    logic [2:0]  in_rm = '0;
    logic        in_is_nan = 1'b0;
    logic        in_is_inf = 1'b0;
    logic [4:0]  in_flags = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [4:0]  out_flags;

    always #5 clk = ~clk;

    fp_round_pack dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_sig     (in_sig),
        .in_rm      (in_rm),
        .in_is_nan  (in_is_nan),
        .in_is_inf  (in_is_inf),
        .in_flags   (in_flags),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          n_pop = 0;
    int          acc_cnt = 0;
    vec_t        tbl[$];
    logic [36:0] expq[$];
    int          idq[$];
    logic [36:0] held;
    bit          hold_pending = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic add(input logic s, input logic [9:0] e, input logic [26:0] g,
                       input logic [2:0] rm, input logic nan, input logic inf,
                       input logic [4:0] fl, input logic [31:0] r, input logic [4:0] ef);
        vec_t t;
        t.sign = s; t.exp = e; t.sig = g; t.rm = rm; t.nan = nan; t.inf = inf;
        t.flags = fl; t.res = r; t.eflags = ef;
        tbl.push_back(t);
    endtask

    task automatic drive(input vec_t t);
        in_sign = t.sign; in_exp = t.exp; in_sig = t.sig; in_rm = t.rm;
        in_is_nan = t.nan; in_is_inf = t.inf; in_flags = t.flags;
    endtask

    // Present one op; the handshake is sampled on the falling edge, before the accepting edge.
    task automatic send(input vec_t t, input int id);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        drive(t);
        in_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (acc) begin
            expq.push_back({t.res, t.eflags});
            idq.push_back(id);
        end else begin
            n_vec++;
            n_err++;
            $display("FAIL accept vec%0d: in_ready low for %0d cycles, required high", id, n);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_queue_empty", 64'(expq.size()), 64'd0);
    endtask

    // Scoreboard and hold-stability monitor
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) acc_cnt++;
        if (rst_n && out_valid) begin
            if (hold_pending) check("hold_stable", 64'({out_result, out_flags}), 64'(held));
            if (out_ready) begin
                hold_pending = 1'b0;
                n_pop++;
                if (expq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_result: got %h/%b, required no output",
                             out_result, out_flags);
                end else begin
                    int id;
                    logic [36:0] e;
                    id = idq.pop_front();
                    e = expq.pop_front();
                    check($sformatf("vec%0d", id), 64'({out_result, out_flags}), 64'(e));
                end
            end else begin
                held = {out_result, out_flags};
                hold_pending = 1'b1;
            end
        end else begin
            hold_pending = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //   sign exp      sig            rm    nan  inf  flags     result        flags
        add(1'b0, 10'd127, 27'h4000000, 3'd0, 1'b0, 1'b0, 5'b00000, 32'h3F800000, 5'b00000);
        add(1'b0, 10'd127, 27'h400000C, 3'd0, 1'b0, 1'b0, 5'b00000, 32'h3F800002, 5'b00001);
        add(1'b0, 10'd127, 27'h4000004, 3'd0, 1'b0, 1'b0, 5'b00000, 32'h3F800000, 5'b00001);
        add(1'b0, 10'd127, 27'h7FFFFFC, 3'd3, 1'b0, 1'b0, 5'b00000, 32'h40000000, 5'b00001);
        add(1'b0, 10'd127, 27'h7FFFFFC, 3'd1, 1'b0, 1'b0, 5'b00000, 32'h3FFFFFFF, 5'b00001);
        add(1'b0, 10'd254, 27'h7FFFFFC, 3'd0, 1'b0, 1'b0, 5'b00000, 32'h7F800000, 5'b00101);
        // Truncation does not carry out of exp 254, so the result stays finite with no OF.
        add(1'b0, 10'd254, 27'h7FFFFFC, 3'd1, 1'b0, 1'b0, 5'b00000, 32'h7F7FFFFF, 5'b00001);
        add(1'b1, 10'd254, 27'h7FFFFFC, 3'd3, 1'b0, 1'b0, 5'b00000, 32'hFF7FFFFF, 5'b00001);
        add(1'b1, 10'd254, 27'h7FFFFFC, 3'd2, 1'b0, 1'b0, 5'b00000, 32'hFF800000, 5'b00101);
        add(1'b0, 10'd254, 27'h7FFFFFC, 3'd3, 1'b0, 1'b0, 5'b00000, 32'h7F800000, 5'b00101);
        add(1'b0, 10'd254, 27'h7FFFFFC, 3'd2, 1'b0, 1'b0, 5'b00000, 32'h7F7FFFFF, 5'b00001);
        add(1'b1, 10'd254, 27'h7FFFFFC, 3'd4, 1'b0, 1'b0, 5'b00000, 32'hFF800000, 5'b00101);
        add(1'b0, 10'd0,   27'h3FFFFFE, 3'd0, 1'b0, 1'b0, 5'b00000, 32'h00800000, 5'b00001);
        add(1'b0, 10'd0,   27'h0000006, 3'd1, 1'b0, 1'b0, 5'b00000, 32'h00000000, 5'b00011);
        add(1'b1, 10'd127, 27'h4000001, 3'd2, 1'b0, 1'b0, 5'b00000, 32'hBF800001, 5'b00001);
        add(1'b1, 10'd127, 27'h4000001, 3'd3, 1'b0, 1'b0, 5'b00000, 32'hBF800000, 5'b00001);
        add(1'b0, 10'd127, 27'h4000004, 3'd4, 1'b0, 1'b0, 5'b00000, 32'h3F800001, 5'b00001);
        add(1'b0, 10'd127, 27'h4000004, 3'd5, 1'b0, 1'b0, 5'b00000, 32'h3F800000, 5'b00001);
        add(1'b0, 10'd127, 27'h400000C, 3'd7, 1'b0, 1'b0, 5'b00000, 32'h3F800002, 5'b00001);
        add(1'b0, 10'd127, 27'h4000007, 3'd0, 1'b1, 1'b0, 5'b10000, 32'h7FC00000, 5'b10000);
        add(1'b1, 10'd127, 27'h4000007, 3'd0, 1'b0, 1'b1, 5'b00000, 32'hFF800000, 5'b00000);
        add(1'b1, 10'd127, 27'h4000007, 3'd0, 1'b1, 1'b1, 5'b00000, 32'h7FC00000, 5'b00000);
        add(1'b1, 10'h3FD, 27'h4000000, 3'd0, 1'b0, 1'b0, 5'b00000, 32'h80000000, 5'b00011);
        add(1'b1, 10'd0,   27'h0000000, 3'd0, 1'b0, 1'b0, 5'b00000, 32'h80000000, 5'b00000);
        add(1'b0, 10'd127, 27'h4000000, 3'd0, 1'b0, 1'b0, 5'b01000, 32'h3F800000, 5'b01000);
        add(1'b0, 10'd127, 27'h400000C, 3'd0, 1'b0, 1'b0, 5'b10000, 32'h3F800002, 5'b10001);
        add(1'b0, 10'd130, 27'h4000008, 3'd3, 1'b0, 1'b0, 5'b00000, 32'h41000001, 5'b00000);
        add(1'b0, 10'd0,   27'h0000008, 3'd0, 1'b0, 1'b0, 5'b00000, 32'h00000001, 5'b00000);
        add(1'b0, 10'd0,   27'h200000C, 3'd0, 1'b0, 1'b0, 5'b00000, 32'h00400002, 5'b00011);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_result", 64'(out_result), 64'd0);
        check("reset_out_flags", 64'(out_flags), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_reset", 64'(in_ready), 64'd1);

        // Latency: result appears on the second edge after the op is presented
        out_ready = 1'b1;
        send(tbl[0], 0);
        check("latency_edge1_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("latency_edge2_out_valid", 64'(out_valid), 64'd1);
        drain();

        // Full table, back to back
        for (int i = 0; i < tbl.size(); i++) send(tbl[i], i);
        drain();

        // Backpressure: two ops fill the pipe, then release
        out_ready = 1'b0;
        acc_cnt = 0;
        fork
            begin
                send(tbl[1], 1);
                send(tbl[3], 3);
                send(tbl[5], 5);
                send(tbl[8], 8);
            end
            begin
                int base;
                repeat (6) @(posedge clk);
                #1;
                check("bp_accepts_before_stall", 64'(acc_cnt), 64'd2);
                check("bp_in_ready_low", 64'(in_ready), 64'd0);
                base = n_pop;
                out_ready = 1'b1;
                repeat (4) @(negedge clk);
                #1;
                check("bp_four_results_four_cycles", 64'(n_pop - base), 64'd4);
            end
        join
        drain();

        // Reset mid-stream: in-flight ops are dropped and never surface
        out_ready = 1'b0;
        drive(tbl[3]);
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_in_ready", 64'(in_ready), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        check("midreset_no_stale", 64'(out_valid), 64'd0);
        send(tbl[12], 12);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
